// File: rtl/level2_map_ctrl_m.sv
// CPU bus-cycle decoder: low-memory window remap, paged-ROM snoop, control
// register file and holdoff-gated req/ack handshake to the clock switcher.
module level2_map_ctrl_m #(
    parameter int unsigned NWIN        = 4,
    parameter int unsigned HOLD_W      = 4,
    parameter int unsigned PAGEREG_W   = 4,
    parameter logic [15:0] PAGEREG_ADR = 16'hFE30
) (
    input  logic            hsclk,
    input  logic            resetb,
    input  logic            cyc_stb,
    input  logic [7:0]      cpu_bank,
    input  logic [15:0]     cpu_adr,
    input  logic            cpu_rnw,
    input  logic            cpu_vda,
    input  logic            cpu_vpa,
    input  logic            wr_stb,
    input  logic [7:0]      wr_data,
    input  logic            hs_ack,
    output logic            rd_en,
    output logic [7:0]      rd_data,
    output logic [7:0]      map_bank,
    output logic [NWIN-1:0] map_hit,
    output logic            dummy_access,
    output logic            hs_req
);
    typedef enum logic [1:0] {
        LS     = 2'd0,
        REQ_HS = 2'd1,
        HS     = 2'd2,
        REQ_LS = 2'd3
    } clk_state_e;

    clk_state_e           state_q, state_d;
    logic                 hs_req_q, hs_req_d;
    logic                 hs_en_q, hs_en_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [HOLD_W-1:0]    cnt_q, cnt_d;
    logic                 wp_viol_q, wp_viol_d;
    logic [PAGEREG_W-1:0] pagereg_q, pagereg_d;

    logic [7:0]           base_q [NWIN];
    logic [7:0]           base_d [NWIN];
    logic [7:0]           lim_q  [NWIN];
    logic [7:0]           lim_d  [NWIN];
    logic [7:0]           tgt_q  [NWIN];
    logic [7:0]           tgt_d  [NWIN];
    logic [NWIN-1:0]      en_q, en_d, wp_q, wp_d, rc_q, rc_d;

    logic                 sel_valid_q, sel_valid_d;
    logic                 sel_rnw_q, sel_rnw_d;
    logic                 snoop_q, snoop_d;
    logic [7:0]           sel_off_q, sel_off_d;

    logic [7:0]           map_bank_q, map_bank_d;
    logic [NWIN-1:0]      map_hit_q, map_hit_d;
    logic                 dummy_q, dummy_d;
    logic                 rd_en_q, rd_en_d;
    logic [7:0]           rd_data_q, rd_data_d;

    logic                 reg_sel, io_cyc, remap_en, win_found, win_wp, wp_block, valid;
    logic [NWIN-1:0]      win_onehot, eff_hit;
    logic [7:0]           win_tgt, eff_bank, rd_val;

    always_comb begin
        state_d     = state_q;
        hs_en_d     = hs_en_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        wp_viol_d   = wp_viol_q;
        pagereg_d   = pagereg_q;
        base_d      = base_q;
        lim_d       = lim_q;
        tgt_d       = tgt_q;
        en_d        = en_q;
        wp_d        = wp_q;
        rc_d        = rc_q;
        sel_valid_d = sel_valid_q;
        sel_rnw_d   = sel_rnw_q;
        snoop_d     = snoop_q;
        sel_off_d   = sel_off_q;
        map_bank_d  = map_bank_q;
        map_hit_d   = map_hit_q;
        dummy_d     = dummy_q;
        rd_en_d     = rd_en_q;
        rd_data_d   = rd_data_q;

        // Writes use the previously latched selection; everything below sees
        // the post-write values so a same-clock read is coherent.
        if (wr_stb && !sel_rnw_q) begin
            if (snoop_q)
                pagereg_d = wr_data[PAGEREG_W-1:0];
            if (sel_valid_q) begin
                case (sel_off_q)
                    8'h00: begin
                        hs_en_d = wr_data[7];
                        hold_d  = wr_data[HOLD_W-1:0];
                    end
                    8'h01:   wp_viol_d = 1'b0;
                    default: ;
                endcase
                for (int unsigned w = 0; w < NWIN; w++) begin
                    if (sel_off_q[7:2] == 6'(4 + w)) begin
                        case (sel_off_q[1:0])
                            2'd0: base_d[w] = wr_data;
                            2'd1: lim_d[w]  = wr_data;
                            2'd2: tgt_d[w]  = wr_data;
                            default: begin
                                en_d[w] = wr_data[0];
                                wp_d[w] = wr_data[1];
                                rc_d[w] = wr_data[2];
                            end
                        endcase
                    end
                end
            end
        end

        valid    = cpu_vda || cpu_vpa;
        reg_sel  = (cpu_bank[7:6] == 2'b10) && cpu_vda;
        io_cyc   = !cpu_bank[7] && (cpu_adr[15:10] == 6'h3F) && cpu_vda;
        remap_en = !cpu_bank[7] && valid;

        win_found  = 1'b0;
        win_onehot = '0;
        win_tgt    = '0;
        win_wp     = 1'b0;
        for (int unsigned w = 0; w < NWIN; w++) begin
            if (!win_found && en_d[w] && (base_d[w] <= cpu_adr[15:8]) &&
                (cpu_adr[15:8] <= lim_d[w]) && (!rc_d[w] || (&pagereg_d))) begin
                win_found     = 1'b1;
                win_onehot[w] = 1'b1;
                win_tgt       = tgt_d[w];
                win_wp        = wp_d[w];
            end
        end
        wp_block = remap_en && win_found && win_wp && !cpu_rnw;
        if (remap_en && win_found && !wp_block) begin
            eff_bank = win_tgt;
            eff_hit  = win_onehot;
        end else begin
            eff_bank = cpu_bank;
            eff_hit  = '0;
        end

        rd_val = '0;
        case (cpu_adr[7:0])
            8'h00: begin
                rd_val[7]          = hs_en_d;
                rd_val[HOLD_W-1:0] = hold_d;
            end
            8'h01: begin
                rd_val[7]             = wp_viol_d;
                rd_val[6:5]           = state_q;
                rd_val[PAGEREG_W-1:0] = pagereg_d;
            end
            default: ;
        endcase
        for (int unsigned w = 0; w < NWIN; w++) begin
            if (cpu_adr[7:2] == 6'(4 + w)) begin
                case (cpu_adr[1:0])
                    2'd0:    rd_val = base_d[w];
                    2'd1:    rd_val = lim_d[w];
                    2'd2:    rd_val = tgt_d[w];
                    default: rd_val = {5'b0, rc_d[w], wp_d[w], en_d[w]};
                endcase
            end
        end

        case (state_q)
            LS:
                if (cyc_stb && hs_en_d && cpu_vpa && cpu_vda && eff_bank[7] &&
                    (cnt_q == '0) && !io_cyc)
                    state_d = REQ_HS;
            REQ_HS:
                if (hs_ack) state_d = HS;
            HS:
                if (cyc_stb && (io_cyc || (valid && !eff_bank[7]) || !hs_en_d))
                    state_d = REQ_LS;
            default:
                if (!hs_ack) state_d = LS;
        endcase
        hs_req_d = (state_d == REQ_HS) || (state_d == HS);

        if (cyc_stb) begin
            sel_valid_d = reg_sel;
            sel_off_d   = cpu_adr[7:0];
            sel_rnw_d   = cpu_rnw;
            snoop_d     = !cpu_bank[7] && cpu_vda && (cpu_adr == PAGEREG_ADR);
            if (wp_block)
                wp_viol_d = 1'b1;
            if (io_cyc)
                cnt_d = hold_d;
            else if (cnt_q != '0)
                cnt_d = cnt_q - HOLD_W'(1);
            map_bank_d = eff_bank;
            map_hit_d  = eff_hit;
            dummy_d    = (eff_bank[7] && valid) || (state_d != LS);
            rd_en_d    = reg_sel && cpu_rnw;
            rd_data_d  = (reg_sel && cpu_rnw) ? rd_val : '0;
        end
    end

    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= LS;
            hs_req_q    <= 1'b0;
            hs_en_q     <= 1'b0;
            hold_q      <= '0;
            cnt_q       <= '0;
            wp_viol_q   <= 1'b0;
            pagereg_q   <= '0;
            for (int unsigned w = 0; w < NWIN; w++) begin
                base_q[w] <= '0;
                lim_q[w]  <= '0;
                tgt_q[w]  <= '0;
            end
            en_q        <= '0;
            wp_q        <= '0;
            rc_q        <= '0;
            sel_valid_q <= 1'b0;
            sel_rnw_q   <= 1'b0;
            snoop_q     <= 1'b0;
            sel_off_q   <= '0;
            map_bank_q  <= '0;
            map_hit_q   <= '0;
            dummy_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            hs_req_q    <= hs_req_d;
            hs_en_q     <= hs_en_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            wp_viol_q   <= wp_viol_d;
            pagereg_q   <= pagereg_d;
            base_q      <= base_d;
            lim_q       <= lim_d;
            tgt_q       <= tgt_d;
            en_q        <= en_d;
            wp_q        <= wp_d;
            rc_q        <= rc_d;
            sel_valid_q <= sel_valid_d;
            sel_rnw_q   <= sel_rnw_d;
            snoop_q     <= snoop_d;
            sel_off_q   <= sel_off_d;
            map_bank_q  <= map_bank_d;
            map_hit_q   <= map_hit_d;
            dummy_q     <= dummy_d;
            rd_en_q     <= rd_en_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_en        = rd_en_q;
    assign rd_data      = rd_data_q;
    assign map_bank     = map_bank_q;
    assign map_hit      = map_hit_q;
    assign dummy_access = dummy_q;
    assign hs_req       = hs_req_q;

endmodule

// File: tb/tb_level2_map_ctrl_m.sv
// Directed bench for level2_map_ctrl_m: remap windows, snoop, registers,
// holdoff and clock handshake, with hand-computed expectations.
module tb_level2_map_ctrl_m;
    logic        hsclk;
    logic        resetb;
    logic        cyc_stb;
    logic [7:0]  cpu_bank;
    logic [15:0] cpu_adr;
    logic        cpu_rnw, cpu_vda, cpu_vpa;
    logic        wr_stb;
    logic [7:0]  wr_data;
    logic        hs_ack;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic [7:0]  map_bank;
    logic [3:0]  map_hit;
    logic        dummy_access;
    logic        hs_req;

    int vectors;
    int miscompares;

    level2_map_ctrl_m #(
        .NWIN(4),
        .HOLD_W(4),
        .PAGEREG_W(4),
        .PAGEREG_ADR(16'hFE30)
    ) dut (
        .hsclk(hsclk),
        .resetb(resetb),
        .cyc_stb(cyc_stb),
        .cpu_bank(cpu_bank),
        .cpu_adr(cpu_adr),
        .cpu_rnw(cpu_rnw),
        .cpu_vda(cpu_vda),
        .cpu_vpa(cpu_vpa),
        .wr_stb(wr_stb),
        .wr_data(wr_data),
        .hs_ack(hs_ack),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .map_bank(map_bank),
        .map_hit(map_hit),
        .dummy_access(dummy_access),
        .hs_req(hs_req)
    );

    initial hsclk = 1'b0;
    always #5 hsclk = ~hsclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU cycle: address phase with cyc_stb, then write data with wr_stb.
    task automatic bus(input logic [7:0] bank, input logic [15:0] adr, input logic rnw,
                       input logic vda, input logic vpa, input logic [7:0] data);
        @(negedge hsclk);
        cpu_bank = bank; cpu_adr = adr; cpu_rnw = rnw;
        cpu_vda = vda; cpu_vpa = vpa; cyc_stb = 1'b1;
        @(negedge hsclk);
        cyc_stb = 1'b0;
        if (!rnw) begin
            wr_data = data;
            wr_stb  = 1'b1;
        end
        @(negedge hsclk);
        wr_stb = 1'b0;
    endtask

    task automatic wreg(input logic [7:0] off, input logic [7:0] val);
        bus(8'h80, {8'h00, off}, 1'b0, 1'b1, 1'b0, val);
    endtask

    task automatic rreg(input string tag, input logic [7:0] off, input logic [7:0] exp);
        bus(8'h80, {8'h00, off}, 1'b1, 1'b1, 1'b0, 8'h00);
        chk({tag, "_rden"}, {31'b0, rd_en}, 32'd1);
        chk(tag, {24'b0, rd_data}, {24'b0, exp});
    endtask

    task automatic acc(input string tag, input logic [7:0] bank, input logic [15:0] adr,
                       input logic rnw, input logic [7:0] exp_bank, input logic [3:0] exp_hit);
        bus(bank, adr, rnw, 1'b1, 1'b0, 8'h5A);
        chk({tag, "_bank"}, {24'b0, map_bank}, {24'b0, exp_bank});
        chk({tag, "_hit"}, {28'b0, map_hit}, {28'b0, exp_hit});
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        resetb = 1'b0; cyc_stb = 1'b0; wr_stb = 1'b0; wr_data = '0;
        cpu_bank = '0; cpu_adr = '0; cpu_rnw = 1'b1; cpu_vda = 1'b0; cpu_vpa = 1'b0;
        hs_ack = 1'b0;
        repeat (2) @(negedge hsclk);
        chk("rst_map_bank", {24'b0, map_bank}, 32'h0);
        chk("rst_hs_req", {31'b0, hs_req}, 32'h0);
        chk("rst_rd_en", {31'b0, rd_en}, 32'h0);
        resetb = 1'b1;

        // Reset in the middle of REQ_HS with hs_ack already high
        wreg(8'h00, 8'h80);
        bus(8'hFF, 16'h1234, 1'b1, 1'b1, 1'b1, 8'h00);
        chk("pre_rst_hs_req", {31'b0, hs_req}, 32'h1);
        chk("pre_rst_dummy", {31'b0, dummy_access}, 32'h1);
        chk("pre_rst_bank", {24'b0, map_bank}, 32'hFF);
        @(negedge hsclk);
        hs_ack = 1'b1; resetb = 1'b0;
        #1;
        chk("midrst_hs_req", {31'b0, hs_req}, 32'h0);
        chk("midrst_dummy", {31'b0, dummy_access}, 32'h0);
        chk("midrst_bank", {24'b0, map_bank}, 32'h0);
        @(negedge hsclk);
        hs_ack = 1'b0; resetb = 1'b1;
        rreg("rst_ctrl", 8'h00, 8'h00);
        rreg("rst_status", 8'h01, 8'h00);
        rreg("rst_w0flags", 8'h13, 8'h00);
        chk("rst_hs_req_after", {31'b0, hs_req}, 32'h0);

        // Window 0: 0x30..0x7F -> bank 0xFE
        wreg(8'h10, 8'h30); wreg(8'h11, 8'h7F); wreg(8'h12, 8'hFE); wreg(8'h13, 8'h01);
        rreg("w0_tgt", 8'h12, 8'hFE);
        acc("w0_3000", 8'h00, 16'h3000, 1'b1, 8'hFE, 4'b0001);
        chk("w0_3000_dummy", {31'b0, dummy_access}, 32'h1);
        acc("w0_2FFF", 8'h00, 16'h2FFF, 1'b1, 8'h00, 4'b0000);
        chk("w0_2FFF_dummy", {31'b0, dummy_access}, 32'h0);
        acc("w0_7FFF", 8'h00, 16'h7FFF, 1'b1, 8'hFE, 4'b0001);
        acc("w0_8000", 8'h00, 16'h8000, 1'b1, 8'h00, 4'b0000);
        acc("hibank_pass", 8'hC3, 16'h3000, 1'b1, 8'hC3, 4'b0000);

        // Window 1 with base > limit never hits
        wreg(8'h14, 8'h80); wreg(8'h15, 8'h10); wreg(8'h16, 8'h66); wreg(8'h17, 8'h01);
        acc("w1_inv_9000", 8'h00, 16'h9000, 1'b1, 8'h00, 4'b0000);
        acc("w1_inv_0500", 8'h00, 16'h0500, 1'b1, 8'h00, 4'b0000);
        // Overlap: window 0 wins, window 1 visible once 0 is disabled
        wreg(8'h14, 8'h40); wreg(8'h15, 8'h50);
        acc("ovl_w0wins", 8'h00, 16'h4400, 1'b1, 8'hFE, 4'b0001);
        wreg(8'h13, 8'h00);
        acc("ovl_w1", 8'h00, 16'h4400, 1'b1, 8'h66, 4'b0010);
        // Write-protect: write not remapped, sticky flag set, cleared by write to 0x01
        wreg(8'h13, 8'h03);
        acc("wp_write", 8'h00, 16'h4000, 1'b0, 8'h00, 4'b0000);
        rreg("wp_status", 8'h01, 8'h80);
        acc("wp_read", 8'h00, 16'h4000, 1'b1, 8'hFE, 4'b0001);
        rreg("wp_sticky", 8'h01, 8'h80);
        wreg(8'h01, 8'h00);
        rreg("wp_cleared", 8'h01, 8'h00);
        wreg(8'h20, 8'hAA);
        rreg("unimpl_20", 8'h20, 8'h00);
        rreg("unimpl_05", 8'h05, 8'h00);

        // rom_cond window 3: 0xA0..0xAF -> 0x33, needs pagereg all-ones
        wreg(8'h1C, 8'hA0); wreg(8'h1D, 8'hAF); wreg(8'h1E, 8'h33); wreg(8'h1F, 8'h05);
        rreg("w3_flags", 8'h1F, 8'h05);
        acc("rc_pg0", 8'h00, 16'hA000, 1'b1, 8'h00, 4'b0000);
        bus(8'h00, 16'hFE30, 1'b0, 1'b1, 1'b0, 8'h0F);
        rreg("snoop_0F", 8'h01, 8'h0F);
        acc("rc_pgF", 8'h00, 16'hA000, 1'b1, 8'h33, 4'b1000);
        bus(8'h00, 16'hFE30, 1'b0, 1'b1, 1'b0, 8'h0C);
        rreg("snoop_0C", 8'h01, 8'h0C);
        acc("rc_pgC", 8'h00, 16'hA000, 1'b1, 8'h00, 4'b0000);

        // Holdoff 3: hs_req rises on the 4th cyc_stb after the IO cycle
        wreg(8'h00, 8'h83);
        bus(8'h00, 16'hFE40, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("io_dummy", {31'b0, dummy_access}, 32'h0);
        chk("io_hs_req", {31'b0, hs_req}, 32'h0);
        bus(8'hFF, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h00);
        chk("hold_f1", {31'b0, hs_req}, 32'h0);
        bus(8'hFF, 16'h0002, 1'b1, 1'b1, 1'b1, 8'h00);
        chk("hold_f2", {31'b0, hs_req}, 32'h0);
        bus(8'hFF, 16'h0004, 1'b1, 1'b1, 1'b1, 8'h00);
        chk("hold_f3", {31'b0, hs_req}, 32'h0);
        bus(8'hFF, 16'h0006, 1'b1, 1'b1, 1'b1, 8'h00);
        chk("hold_f4", {31'b0, hs_req}, 32'h1);
        chk("hold_f4_dummy", {31'b0, dummy_access}, 32'h1);
        @(negedge hsclk);
        hs_ack = 1'b1;
        @(negedge hsclk);
        chk("hs_state_req", {31'b0, hs_req}, 32'h1);
        rreg("hs_status", 8'h01, 8'h4C);
        chk("hs_after_reg", {31'b0, hs_req}, 32'h1);
        acc("hs_lowacc", 8'h00, 16'h1000, 1'b1, 8'h00, 4'b0000);
        chk("req_ls_hs_req", {31'b0, hs_req}, 32'h0);
        chk("req_ls_dummy", {31'b0, dummy_access}, 32'h1);
        rreg("req_ls_status", 8'h01, 8'h6C);
        hs_ack = 1'b0;
        @(negedge hsclk);
        acc("ls_lowacc", 8'h00, 16'h1000, 1'b1, 8'h00, 4'b0000);
        chk("ls_dummy", {31'b0, dummy_access}, 32'h0);
        hs_ack = 1'b1;
        repeat (3) @(negedge hsclk);
        chk("ls_ack_ignored", {31'b0, hs_req}, 32'h0);
        rreg("ls_status", 8'h01, 8'h0C);
        hs_ack = 1'b0;

        // Same-clock cyc_stb + wr_stb: write lands on old selection, new one latched
        @(negedge hsclk);
        cpu_bank = 8'h80; cpu_adr = 16'h0000; cpu_rnw = 1'b0;
        cpu_vda = 1'b1; cpu_vpa = 1'b0; cyc_stb = 1'b1;
        @(negedge hsclk);
        cpu_adr = 16'h0012; wr_data = 8'h85; wr_stb = 1'b1;
        @(negedge hsclk);
        cyc_stb = 1'b0; wr_data = 8'h44;
        @(negedge hsclk);
        wr_stb = 1'b0;
        chk("same_clk_rden", {31'b0, rd_en}, 32'h0);
        rreg("same_clk_ctrl", 8'h00, 8'h85);
        rreg("same_clk_newsel", 8'h12, 8'h44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
